// File: rtl/byte_state_packer.sv
// -----------------------------------------------------------------------------
// byte_state_packer
//
// Collects a stream of bytes into one 128-bit AES state (4 x 32-bit words) and
// presents the finished block to a consumer with a valid/ready handshake.
// Bytes are placed column-major: byte k lands in word k>>2, lane k[1:0], with
// lane 0 at bits [7:0] of the word. A partially filled block can be closed
// early with flush; the lanes that were never written read as zero.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : in_byte carries a byte this cycle
//   in_ready   : the packer accepts in_byte this cycle (low while a block is held)
//   in_byte    : incoming data byte
//   flush      : close a partially filled block, zero-padding the rest
//   out_valid  : out_state holds a complete block
//   out_ready  : the consumer accepts out_state this cycle
//   out_state  : assembled block, word w at bits [32w+31:32w]
//   out_count  : number of real (non-pad) bytes in out_state, 1..16; 0 when idle
//   busy       : at least one byte accepted and the block not yet delivered
//
// Parameters
//   NUM_WORDS  : words per block; only 4 (one 128-bit AES state) is supported
// -----------------------------------------------------------------------------
module byte_state_packer #(
   parameter int NUM_WORDS = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_byte,
   input  logic         flush,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic [4:0]   out_count,
   output logic         busy
);

   // Byte count of a full block; the count register is 5 bits so it can
   // represent the full value 16 while the block is held.
   localparam logic [4:0] FULL_COUNT = 5'(4 * NUM_WORDS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // no bytes held
      ST_FILL = 2'd1,   // 1..15 bytes held
      ST_HOLD = 2'd2    // block presented to the consumer
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [4:0] count_q;
   logic [4:0] count_d;

   // [word][lane][bit]: the packed layout flattens so that word w, lane l sits
   // at bits [32w+8l+7 : 32w+8l], which is exactly the out_state format.
   logic [NUM_WORDS-1:0][3:0][7:0] buffer_q;

   logic accept_int;    // in_ready before the reset override
   logic xfer;          // a byte is transferred this cycle
   logic deliver;       // the held block is handed over this cycle
   logic write_en;      // store in_byte at position count_q
   logic clear_buf;     // wipe the buffer after delivery

   assign accept_int = (state_q != ST_HOLD);
   assign xfer       = in_valid && accept_int;
   assign deliver    = (state_q == ST_HOLD) && out_ready;

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path through
      // the case statement leaves one unassigned and no latch is inferred.
      state_d   = state_q;
      count_d   = count_q;
      write_en  = 1'b0;
      clear_buf = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // A bare flush with nothing held is ignored: empty blocks are
            // never emitted.
            if (xfer) begin
               write_en = 1'b1;
               count_d  = 5'd1;
               state_d  = flush ? ST_HOLD : ST_FILL;
            end
         end

         ST_FILL: begin
            if (xfer) begin
               write_en = 1'b1;
               count_d  = count_q + 5'd1;
            end
            // NOTE: blocking assignments in always_comb take effect in order,
            // so count_d below already includes a byte stored this cycle;
            // that is what makes "store first, then flush" fall out naturally.
            if ((count_d == FULL_COUNT) || flush) begin
               state_d = ST_HOLD;
            end
         end

         ST_HOLD: begin
            // Flush and input bytes are ignored here (in_ready is low); only
            // the output handshake releases the block.
            if (deliver) begin
               state_d   = ST_IDLE;
               count_d   = 5'd0;
               clear_buf = 1'b1;
            end
         end

         default: begin
            state_d   = ST_IDLE;
            count_d   = 5'd0;
            clear_buf = 1'b1;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State, counter and buffer registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         count_q  <= 5'd0;
         // NOTE: the data buffer is reset too, not just the control state:
         // the zero padding of a flushed block relies on unwritten lanes
         // already being zero, and out_state must read zero after reset.
         buffer_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (clear_buf) begin
            buffer_q <= '0;
         end else if (write_en) begin
            // Only the addressed lane is written; the other three lanes of the
            // word keep their contents.
            buffer_q[count_q[3:2]][count_q[1:0]] <= in_byte;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   // The outputs are forced to their reset values while rst_n is low, so they
   // read correctly during reset even before the first clock edge has cleared
   // the registers. Reset still wins over any transfer because the registers
   // ignore everything else while rst_n is low.
   assign in_ready  = !rst_n || accept_int;
   assign out_valid = rst_n && (state_q == ST_HOLD);
   assign busy      = rst_n && (state_q != ST_IDLE);
   assign out_count = out_valid ? count_q : 5'd0;
   assign out_state = rst_n ? buffer_q : '0;

endmodule
